// File: rtl/semaphore_phase_controller.sv
// ---------------------------------------------------------------------------
// semaphore_phase_controller
//
// N-phase traffic-light controller. Each state is timed internally by
// counting the one-cycle `tick` enable from the shared prescaler. Phases
// are served in cyclic order, skipping phases whose `phase_en` bit is low.
// Each GREEN is followed by YELLOW and an all-red clearance interval.
// A latched pedestrian request for a phase extends that phase's next green.
//
// Optional feature (macro SEMAPHORE_FLASH_EN):
//   Adds the `flash` input. It forces a blinking-yellow FLASH state. On
//   release the block restarts through ALLRED, then serves phase 0 first
//   (or the next enabled phase after it).
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-high reset
//   tick          one-cycle timing enable
//   flash         (SEMAPHORE_FLASH_EN only) force blinking-yellow mode
//   phase_en      per-phase enable mask, bit p=1 means phase p is served
//   ped_req       per-phase pedestrian request (pulse or level)
//   road_light    per phase {red,yellow,green}
//   ped_light     per phase {dont_walk,walk}
//   active_phase  phase currently served
//   ped_pending   latched, not yet served pedestrian requests
//   state_flag    current state register (GREEN=0 YELLOW=1 ALLRED=2 FLASH=3)
// ---------------------------------------------------------------------------
module semaphore_phase_controller #(
    parameter int NUM_PHASES    = 4,
    parameter int TIMER_W       = 12,
    parameter int GREEN_TICKS   = 20,
    parameter int PED_EXT_TICKS = 10,
    parameter int YELLOW_TICKS  = 4,
    parameter int ALLRED_TICKS  = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          tick,
`ifdef SEMAPHORE_FLASH_EN
    input  logic                          flash,
`endif
    input  logic [NUM_PHASES-1:0]         phase_en,
    input  logic [NUM_PHASES-1:0]         ped_req,
    output logic [3*NUM_PHASES-1:0]       road_light,
    output logic [2*NUM_PHASES-1:0]       ped_light,
    output logic [$clog2(NUM_PHASES)-1:0] active_phase,
    output logic [NUM_PHASES-1:0]         ped_pending,
    output logic [1:0]                    state_flag
);

    localparam int PW = $clog2(NUM_PHASES);

    localparam logic [TIMER_W-1:0] T_GREEN     = TIMER_W'(GREEN_TICKS - 1);
    localparam logic [TIMER_W-1:0] T_GREEN_EXT = TIMER_W'(GREEN_TICKS + PED_EXT_TICKS - 1);
    localparam logic [TIMER_W-1:0] T_YELLOW    = TIMER_W'(YELLOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] T_ALLRED    = TIMER_W'(ALLRED_TICKS - 1);

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2,
        S_FLASH  = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic [PW-1:0]        active_n;
    logic [NUM_PHASES-1:0] pend_n;
    // Set when leaving FLASH: the next phase search starts at phase 0
    // instead of active_phase+1.
    logic                 restart, restart_n;
`ifdef SEMAPHORE_FLASH_EN
    logic                 blink, blink_n;   // 1 = yellow lamps lit in FLASH
`endif

    logic                 expire;
    logic [PW-1:0]        next_phase;
    logic [PW-1:0]        cand;
    logic                 found;
    int                   search_base;

    assign state_flag = state;
    assign expire     = tick && (timer == '0);

    // Next phase to serve: first enabled phase searched cyclically from
    // search_base. The last candidate is the current phase itself, so a
    // lone enabled phase is re-served.
    always_comb begin
        next_phase  = active_phase;
        found       = 1'b0;
        cand        = '0;
        search_base = restart ? 0 : int'(active_phase) + 1;
        for (int k = 0; k < NUM_PHASES; k++) begin
            cand = PW'((search_base + k) % NUM_PHASES);
            if (!found && phase_en[cand]) begin
                next_phase = cand;
                found      = 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        active_n  = active_phase;
        pend_n    = ped_pending | ped_req;
        restart_n = restart;
`ifdef SEMAPHORE_FLASH_EN
        blink_n   = blink;
`endif
        if (tick && (timer != '0)) begin
            timer_n = timer - 1'b1;
        end

        case (state)
            S_GREEN: begin
                if (expire) begin
                    state_n = S_YELLOW;
                    timer_n = T_YELLOW;
                end
            end
            S_YELLOW: begin
                if (expire) begin
                    state_n = S_ALLRED;
                    timer_n = T_ALLRED;
                end
            end
            S_ALLRED: begin
                if (expire) begin
                    if (phase_en == '0) begin
                        // Nothing to serve: hold all-red and re-time it.
                        timer_n = T_ALLRED;
                    end else begin
                        state_n   = S_GREEN;
                        active_n  = next_phase;
                        restart_n = 1'b0;
                        // Clearing here wins over a request in the same cycle.
                        if (ped_pending[next_phase] || ped_req[next_phase]) begin
                            timer_n            = T_GREEN_EXT;
                            pend_n[next_phase] = 1'b0;
                        end else begin
                            timer_n = T_GREEN;
                        end
                    end
                end
            end
            default: begin
                // FLASH with flash released (or an illegal code when the
                // feature is absent): recover through all-red.
                state_n = S_ALLRED;
                timer_n = T_ALLRED;
`ifdef SEMAPHORE_FLASH_EN
                restart_n = 1'b1;
`endif
            end
        endcase

`ifdef SEMAPHORE_FLASH_EN
        // flash overrides every transition; requests keep latching.
        if (flash) begin
            state_n   = S_FLASH;
            timer_n   = timer;
            active_n  = active_phase;
            restart_n = restart;
            pend_n    = ped_pending | ped_req;
            if (state != S_FLASH) begin
                blink_n = 1'b1;
            end else if (tick) begin
                blink_n = ~blink;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_GREEN;
            timer        <= T_GREEN;
            active_phase <= '0;
            ped_pending  <= '0;
            restart      <= 1'b0;
`ifdef SEMAPHORE_FLASH_EN
            blink        <= 1'b1;
`endif
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            active_phase <= active_n;
            ped_pending  <= pend_n;
            restart      <= restart_n;
`ifdef SEMAPHORE_FLASH_EN
            blink        <= blink_n;
`endif
        end
    end

    // Moore lamp decode. Non-active roads/peds stay red/dont-walk.
    always_comb begin
        road_light = '0;
        ped_light  = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            road_light[3*p +: 3] = 3'b100;
            ped_light[2*p +: 2]  = 2'b10;
            if (active_phase == PW'(p)) begin
                if (state == S_GREEN) begin
                    road_light[3*p +: 3] = 3'b001;
                    ped_light[2*p +: 2]  = 2'b01;
                end else if (state == S_YELLOW) begin
                    road_light[3*p +: 3] = 3'b010;
                end
            end
`ifdef SEMAPHORE_FLASH_EN
            if (state == S_FLASH) begin
                road_light[3*p +: 3] = blink ? 3'b010 : 3'b000;
            end
`endif
        end
    end

endmodule

// File: tb/tb_semaphore_phase_controller.sv
// ---------------------------------------------------------------------------
// tb_semaphore_phase_controller
//
// Directed scenarios followed by a randomized run. A behavioural model that
// tracks "ticks remaining" per interval predicts every output after each
// clock edge; directed steps also measure interval lengths in cycles.
// ---------------------------------------------------------------------------
module tb_semaphore_phase_controller;

    localparam int N  = 4;
    localparam int PW = 2;
    localparam int G  = 20;
    localparam int E  = 10;
    localparam int Y  = 4;
    localparam int A  = 2;

    // clock / reset / inputs
    logic          clock = 1'b0;
    logic          reset;
    logic          tick;
`ifdef SEMAPHORE_FLASH_EN
    logic          flash;
`endif
    logic [N-1:0]  phase_en;
    logic [N-1:0]  ped_req;
    logic [3*N-1:0] road_light;
    logic [2*N-1:0] ped_light;
    logic [PW-1:0] active_phase;
    logic [N-1:0]  ped_pending;
    logic [1:0]    state_flag;

    semaphore_phase_controller #(
        .NUM_PHASES(N), .TIMER_W(12), .GREEN_TICKS(G),
        .PED_EXT_TICKS(E), .YELLOW_TICKS(Y), .ALLRED_TICKS(A)
    ) dut (
        .clock(clock),
        .reset(reset),
        .tick(tick),
`ifdef SEMAPHORE_FLASH_EN
        .flash(flash),
`endif
        .phase_en(phase_en),
        .ped_req(ped_req),
        .road_light(road_light),
        .ped_light(ped_light),
        .active_phase(active_phase),
        .ped_pending(ped_pending),
        .state_flag(state_flag)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tick_period = 1;
    bit auto_tick = 1'b1;
    int prev_state = 0;
    logic [N-1:0] prev_pend = '0;

    // reference model
    int m_state;   // 0 green, 1 yellow, 2 all-red, 3 flash
    int m_phase;
    int m_left;    // ticks still to elapse in the current interval
    logic [N-1:0] m_pend;
    bit m_restart;
    bit m_blink;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_phase   = 0;
        m_left    = G;
        m_pend    = '0;
        m_restart = 1'b0;
        m_blink   = 1'b1;
    endtask

    task automatic model_step();
        logic [N-1:0] np;
        int start;
        int p;
        if (reset) begin
            model_reset();
            return;
        end
        np = m_pend | ped_req;
`ifdef SEMAPHORE_FLASH_EN
        if (flash) begin
            if (m_state != 3) m_blink = 1'b1;
            else if (tick) m_blink = !m_blink;
            m_state = 3;
            m_pend  = np;
            return;
        end
        if (m_state == 3) begin
            m_state   = 2;
            m_left    = A;
            m_restart = 1'b1;
            m_pend    = np;
            return;
        end
`endif
        if (tick) begin
            m_left--;
            if (m_left == 0) begin
                if (m_state == 0) begin
                    m_state = 1;
                    m_left  = Y;
                end else if (m_state == 1) begin
                    m_state = 2;
                    m_left  = A;
                end else if (phase_en == '0) begin
                    m_left = A;
                end else begin
                    start = m_restart ? 0 : m_phase + 1;
                    p = -1;
                    for (int k = 0; k < N; k++)
                        if (p < 0 && phase_en[PW'((start + k) % N)]) p = (start + k) % N;
                    m_state   = 0;
                    m_phase   = p;
                    m_restart = 1'b0;
                    if (np[PW'(p)]) begin
                        m_left = G + E;
                        np[PW'(p)] = 1'b0;
                    end else begin
                        m_left = G;
                    end
                end
            end
        end
        m_pend = np;
    endtask

    task automatic exp_lamps(output logic [3*N-1:0] r, output logic [2*N-1:0] pd);
        r  = '0;
        pd = '0;
        for (int p = 0; p < N; p++) begin
            r[3*p +: 3]  = 3'b100;
            pd[2*p +: 2] = 2'b10;
            if (p == m_phase && m_state == 0) begin
                r[3*p +: 3]  = 3'b001;
                pd[2*p +: 2] = 2'b01;
            end
            if (p == m_phase && m_state == 1) r[3*p +: 3] = 3'b010;
            if (m_state == 3) r[3*p +: 3] = m_blink ? 3'b010 : 3'b000;
        end
    endtask

    task automatic check_all();
        logic [3*N-1:0] er;
        logic [2*N-1:0] ep;
        exp_lamps(er, ep);
        chk("model_state",   32'(state_flag),   32'(m_state));
        chk("model_active",  32'(active_phase), 32'(m_phase));
        chk("model_pending", 32'(ped_pending),  32'(m_pend));
        chk("model_road",    32'(road_light),   32'(er));
        chk("model_ped",     32'(ped_light),    32'(ep));
    endtask

    // One clock: drive tick, take the edge, advance the model, sample #1 later.
    task automatic cycle();
        if (auto_tick) tick = ((cyc % tick_period) == tick_period - 1);
        prev_state = int'(state_flag);
        prev_pend  = ped_pending;
        @(posedge clock);
        model_step();
        cyc++;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cyc = 0;
    endtask

    // Run until the next GREEN entry; report the phase entered.
    task automatic wait_entry(input string tag, output int ph);
        bit ok;
        ok = 1'b0;
        ph = -1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            cycle();
            if (state_flag == 2'd0 && prev_state == 2) begin
                ok = 1'b1;
                ph = int'(active_phase);
            end
        end
        chk({tag, "_reached"}, 32'(ok), 32'd1);
    endtask

    // Length in cycles of the current state, counting cnt0 already seen.
    task automatic measure(input int st, input int cnt0, output int len);
        len = cnt0;
        for (int i = 0; i < 2000 && int'(state_flag) == st; i++) begin
            cycle();
            if (int'(state_flag) == st) len++;
        end
    endtask

    logic [3*N-1:0] all_red;
    logic [3*N-1:0] all_yel;

    initial begin
        int len;
        int ph;
        bit ok;
        for (int p = 0; p < N; p++) begin
            all_red[3*p +: 3] = 3'b100;
            all_yel[3*p +: 3] = 3'b010;
        end
        reset = 1'b1;
        tick = 1'b0;
        phase_en = 4'b1111;
        ped_req = '0;
`ifdef SEMAPHORE_FLASH_EN
        flash = 1'b0;
`endif
        model_reset();

        // 1: default rotation, tick every cycle (tick during reset ignored)
        tick_period = 1;
        do_reset();
        chk("reset_road", 32'(road_light), 32'(12'b100_100_100_001));
        chk("reset_ped",  32'(ped_light),  32'(8'b10_10_10_01));
        measure(0, 1, len);
        chk("green0_len", 32'(len), 32'd20);
        chk("seq_yellow", 32'(state_flag), 32'd1);
        measure(1, 1, len);
        chk("yellow_len", 32'(len), 32'd4);
        chk("seq_allred", 32'(state_flag), 32'd2);
        measure(2, 1, len);
        chk("allred_len", 32'(len), 32'd2);
        chk("seq_green",  32'(state_flag), 32'd0);
        chk("phase1",     32'(active_phase), 32'd1);
        wait_entry("rot2", ph); chk("rot_phase2", 32'(ph), 32'd2);
        wait_entry("rot3", ph); chk("rot_phase3", 32'(ph), 32'd3);
        wait_entry("rot0", ph); chk("rot_wrap0",  32'(ph), 32'd0);

        // 2: tick every 5th cycle
        tick_period = 5;
        do_reset();
        measure(0, 1, len);
        chk("green0_slow_len", 32'(len), 32'd100);
        tick_period = 1;

        // 3: one-cycle request for phase 2 during phase 0 green
        do_reset();
        repeat (3) cycle();
        ped_req = 4'b0100;
        cycle();
        ped_req = '0;
        chk("ped2_latched", 32'(ped_pending), 32'(4'b0100));
        wait_entry("p3a", ph); chk("p3_phase1", 32'(ph), 32'd1);
        wait_entry("p3b", ph); chk("p3_phase2", 32'(ph), 32'd2);
        chk("ped2_held_to_entry", 32'(prev_pend), 32'(4'b0100));
        chk("ped2_cleared", 32'(ped_pending), 32'd0);
        chk("ped2_walk", 32'(ped_light[5:4]), 32'(2'b01));
        measure(0, 1, len);
        chk("green2_ext_len", 32'(len), 32'd30);

        // 4: request for phase 1 held across its green entry
        do_reset();
        ped_req = 4'b0010;
        wait_entry("p4a", ph); chk("p4_phase1", 32'(ph), 32'd1);
        chk("ped1_clear_at_entry", 32'(ped_pending), 32'd0);
        cycle();
        chk("ped1_relatched", 32'(ped_pending), 32'(4'b0010));
        ped_req = '0;
        measure(0, 2, len);
        chk("green1_ext_len", 32'(len), 32'd30);
        for (int k = 0; k < 4; k++) begin
            wait_entry("p4b", ph);
            if (ph == 1) break;
        end
        chk("p4_phase1_again", 32'(active_phase), 32'd1);
        measure(0, 1, len);
        chk("green1_ext_again", 32'(len), 32'd30);

        // 5: skipped phases, then nothing enabled
        phase_en = 4'b1001;
        do_reset();
        chk("en1001_first", 32'(active_phase), 32'd0);
        wait_entry("s1", ph); chk("en1001_p3a", 32'(ph), 32'd3);
        wait_entry("s2", ph); chk("en1001_p0",  32'(ph), 32'd0);
        wait_entry("s3", ph); chk("en1001_p3b", 32'(ph), 32'd3);
        phase_en = '0;
        repeat (200) cycle();
        chk("none_en_state", 32'(state_flag), 32'd2);
        chk("none_en_road",  32'(road_light), 32'(all_red));
        phase_en = 4'b0100;
        wait_entry("s4", ph); chk("reenable_p2", 32'(ph), 32'd2);

        // 6: reset in the middle of phase 2 yellow
        phase_en = 4'b1111;
        do_reset();
        ped_req = 4'b1000;
        cycle();
        ped_req = '0;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            cycle();
            if (state_flag == 2'd1 && active_phase == 2'd2) ok = 1'b1;
        end
        chk("yellow2_reached", 32'(ok), 32'd1);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cyc = 0;
        chk("midrst_state",   32'(state_flag),   32'd0);
        chk("midrst_active",  32'(active_phase), 32'd0);
        chk("midrst_pending", 32'(ped_pending),  32'd0);
`ifdef SEMAPHORE_FLASH_EN
        flash = 1'b1;
        cycle();
        chk("flash_state", 32'(state_flag), 32'd3);
        chk("flash_on",    32'(road_light), 32'(all_yel));
        cycle();
        chk("flash_off",   32'(road_light), 32'd0);
        repeat (6) cycle();
        flash = 1'b0;
        cycle();
        chk("unflash_allred", 32'(state_flag), 32'd2);
        measure(2, 1, len);
        chk("unflash_allred_len", 32'(len), 32'd2);
        chk("unflash_green", 32'(state_flag), 32'd0);
        chk("unflash_p0",    32'(active_phase), 32'd0);
        phase_en = 4'b0110;
        flash = 1'b1;
        repeat (3) cycle();
        flash = 1'b0;
        wait_entry("uf", ph); chk("unflash_p1", 32'(ph), 32'd1);
        phase_en = 4'b1111;
`endif

        // 7: randomized run against the model
        auto_tick = 1'b0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) phase_en = N'($urandom);
            ped_req = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
            reset = ($urandom_range(0, 499) == 0);
`ifdef SEMAPHORE_FLASH_EN
            if ($urandom_range(0, 149) == 0) flash = !flash;
`endif
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
